// File: rtl/cpu_controller.sv
// cpu_controller: instruction-sequencing FSM that latches one 16-bit
// instruction per start handshake and drives every datapath control input
// through the read, execute and write-back cycles.
module cpu_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        waiting,
  output logic        done,
  output logic        illegal,
  output logic [15:0] datapath_in,
  output logic        wb_sel,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic [2:0]  r_addr,
  output logic        en_A,
  output logic        en_B,
  output logic [1:0]  shift_op,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  ALU_op,
  output logic        en_C,
  output logic        en_status
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WR_IMM, S_WR_REG
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;

  // Instruction fields of the latched IR.
  logic [2:0] w_opc;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [2:0] w_rm;
  assign w_opc = r_ir[15:13];
  assign w_op  = r_ir[12:11];
  assign w_rn  = r_ir[10:8];
  assign w_rd  = r_ir[7:5];
  assign w_rm  = r_ir[2:0];

  // Decoded instruction class.
  logic w_is_movi, w_is_movr, w_is_alu, w_is_cmp, w_is_mvn, w_uses_a, w_legal;
  assign w_is_movi = (w_opc == 3'b110) && (w_op == 2'b10);
  assign w_is_movr = (w_opc == 3'b110) && (w_op == 2'b00);
  assign w_is_alu  = (w_opc == 3'b101);
  assign w_is_cmp  = w_is_alu && (w_op == 2'b01);
  assign w_is_mvn  = w_is_alu && (w_op == 2'b11);
  assign w_uses_a  = w_is_alu && !w_is_mvn;
  assign w_legal   = w_is_movi || w_is_movr || w_is_alu;

  // Fields that are pure functions of IR, independent of state.
  assign datapath_in = {{8{r_ir[7]}}, r_ir[7:0]};
  assign shift_op    = r_ir[4:3];
  assign sel_B       = 1'b0;
  assign ALU_op      = w_is_alu ? w_op : 2'b00;

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_WAIT;
    else     r_state <= w_next;
  end

  // Instruction register: loads only on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: IR is a single control register, so it is reset (to 0) along with
    // the state; it must not hold a stale instruction after reset.
    if (rst)                               r_ir <= 16'h0000;
    else if ((r_state == S_WAIT) && start) r_ir <= instr;
  end

  // Next-state and Moore control outputs.
  always_comb begin
    // NOTE: every output and w_next gets a default first so no path through
    // the case can leave a signal unassigned and infer a latch.
    w_next    = r_state;
    waiting   = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    wb_sel    = 1'b0;
    w_addr    = w_rd;
    w_en      = 1'b0;
    r_addr    = w_rn;
    en_A      = 1'b0;
    en_B      = 1'b0;
    sel_A     = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        waiting = 1'b1;
        if (start) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (!w_legal) begin
          illegal = 1'b1;
          w_next  = S_WAIT;
        end else if (w_is_movi) begin
          w_next = S_WR_IMM;
        end else if (w_uses_a) begin
          w_next = S_LOAD_A;
        end else begin
          w_next = S_LOAD_B;
        end
      end
      S_LOAD_A: begin
        r_addr = w_rn;
        en_A   = 1'b1;
        w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        r_addr = w_rm;
        en_B   = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        en_C  = 1'b1;
        sel_A = w_is_movr || w_is_mvn;
        if (w_is_cmp) begin
          en_status = 1'b1;
          done      = 1'b1;
          w_next    = S_WAIT;
        end else begin
          w_next = S_WR_REG;
        end
      end
      S_WR_IMM: begin
        wb_sel = 1'b1;
        w_addr = w_rn;
        w_en   = 1'b1;
        done   = 1'b1;
        w_next = S_WAIT;
      end
      S_WR_REG: begin
        wb_sel = 1'b0;
        w_addr = w_rd;
        w_en   = 1'b1;
        done   = 1'b1;
        w_next = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: a reference model pushes the
// expected per-cycle control bundle into a queue as each instruction is
// driven; every sampled cycle pops and compares the full bundle.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] instr;
  logic        waiting, done, illegal, wb_sel, w_en, en_A, en_B;
  logic        sel_A, sel_B, en_C, en_status;
  logic [15:0] datapath_in;
  logic [2:0]  w_addr, r_addr;
  logic [1:0]  shift_op, ALU_op;

  cpu_controller dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr),
    .waiting(waiting), .done(done), .illegal(illegal),
    .datapath_in(datapath_in), .wb_sel(wb_sel), .w_addr(w_addr),
    .w_en(w_en), .r_addr(r_addr), .en_A(en_A), .en_B(en_B),
    .shift_op(shift_op), .sel_A(sel_A), .sel_B(sel_B), .ALU_op(ALU_op),
    .en_C(en_C), .en_status(en_status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        waiting;
    logic        done;
    logic        illegal;
    logic [15:0] datapath_in;
    logic        wb_sel;
    logic [2:0]  w_addr;
    logic        w_en;
    logic [2:0]  r_addr;
    logic        en_A;
    logic        en_B;
    logic [1:0]  shift_op;
    logic        sel_A;
    logic        sel_B;
    logic [1:0]  ALU_op;
    logic        en_C;
    logic        en_status;
  } ctl_t;

  typedef enum {T_WAIT, T_DEC, T_LA, T_LB, T_EX, T_WI, T_WR} stage_t;
  typedef enum {C_MOVI, C_MOVR, C_ADD, C_CMP, C_AND, C_MVN, C_ILL} cls_t;

  typedef struct {
    logic [15:0] ir;
    int          lat;
    string       name;
  } vec_t;

  ctl_t act;
  assign act = {waiting, done, illegal, datapath_in, wb_sel, w_addr, w_en,
                r_addr, en_A, en_B, shift_op, sel_A, sel_B, ALU_op, en_C,
                en_status};

  ctl_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic cls_t classify(input logic [15:0] ir);
    case ({ir[15:13], ir[12:11]})
      5'b110_10: return C_MOVI;
      5'b110_00: return C_MOVR;
      5'b101_00: return C_ADD;
      5'b101_01: return C_CMP;
      5'b101_10: return C_AND;
      5'b101_11: return C_MVN;
      default:   return C_ILL;
    endcase
  endfunction

  // Reference: expected control bundle for a given stage and latched IR.
  function automatic ctl_t exp_out(input stage_t st, input logic [15:0] ir);
    ctl_t o;
    cls_t c;
    c             = classify(ir);
    o             = '0;
    o.datapath_in = {{8{ir[7]}}, ir[7:0]};
    o.shift_op    = ir[4:3];
    o.r_addr      = ir[10:8];
    o.w_addr      = ir[7:5];
    o.ALU_op      = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
    case (st)
      T_WAIT: o.waiting = 1'b1;
      T_DEC:  o.illegal = (c == C_ILL);
      T_LA:   o.en_A = 1'b1;
      T_LB:   begin o.en_B = 1'b1; o.r_addr = ir[2:0]; end
      T_EX:   begin
        o.en_C      = 1'b1;
        o.sel_A     = (c == C_MOVR) || (c == C_MVN);
        o.en_status = (c == C_CMP);
        o.done      = (c == C_CMP);
      end
      T_WI:   begin o.wb_sel = 1'b1; o.w_addr = ir[10:8]; o.w_en = 1'b1; o.done = 1'b1; end
      T_WR:   begin o.w_en = 1'b1; o.done = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  // Push the expected busy-cycle sequence for one accepted instruction.
  task automatic push_seq(input logic [15:0] ir);
    exp_q.push_back(exp_out(T_DEC, ir));
    case (classify(ir))
      C_MOVI: exp_q.push_back(exp_out(T_WI, ir));
      C_MOVR, C_MVN: begin
        exp_q.push_back(exp_out(T_LB, ir));
        exp_q.push_back(exp_out(T_EX, ir));
        exp_q.push_back(exp_out(T_WR, ir));
      end
      C_ADD, C_AND: begin
        exp_q.push_back(exp_out(T_LA, ir));
        exp_q.push_back(exp_out(T_LB, ir));
        exp_q.push_back(exp_out(T_EX, ir));
        exp_q.push_back(exp_out(T_WR, ir));
      end
      C_CMP: begin
        exp_q.push_back(exp_out(T_LA, ir));
        exp_q.push_back(exp_out(T_LB, ir));
        exp_q.push_back(exp_out(T_EX, ir));
      end
      default: ;
    endcase
  endtask

  task automatic pop_check(input string name);
    ctl_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %h expected <no entry>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(act), 64'(e));
    end
  endtask

  // Issue one instruction from WAIT (called at a negedge), compare `lat` busy
  // cycles from the scoreboard, then the return-to-WAIT cycle. An optional
  // start pulse with a different instruction is injected while busy.
  task automatic run(input logic [15:0] ir, input int lat, input string name,
                     input int pulse_at);
    start = 1'b1;
    instr = ir;
    push_seq(ir);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      pop_check($sformatf("%s_cyc%0d", name, c));
      start = 1'b0;
      if (c == pulse_at) begin
        start = 1'b1;
        instr = 16'hD1FE;
      end
    end
    @(negedge clk);
    check({name, "_return_wait"}, 64'(act), 64'(exp_out(T_WAIT, ir)));
    start = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'hD005, 2, "movi_r0_5"});
    vecs.push_back('{16'hD1FE, 2, "movi_r1_m2"});
    vecs.push_back('{16'hA041, 5, "add_r2_r0_r1"});
    vecs.push_back('{16'hA801, 4, "cmp_r0_r1"});
    vecs.push_back('{16'hB860, 4, "mvn_r3_r0"});
    vecs.push_back('{16'hC06A, 4, "movr_r3_r2"});
    vecs.push_back('{16'hB183, 5, "and_r4_r1_r3"});
    vecs.push_back('{16'h0000, 1, "illegal_0000"});
    vecs.push_back('{16'hD800, 1, "illegal_110_11"});
    vecs.push_back('{16'hC800, 1, "illegal_110_01"});
    vecs.push_back('{16'hE000, 1, "illegal_111"});

    rst   = 1'b1;
    start = 1'b0;
    instr = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_state", 64'(act), 64'(exp_out(T_WAIT, 16'h0000)));
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 64'(act), 64'(exp_out(T_WAIT, 16'h0000)));

    // Table-driven instruction vectors.
    foreach (vecs[i]) run(vecs[i].ir, vecs[i].lat, vecs[i].name, -1);

    // start pulsed while busy: ignored, IR (and thus outputs) unchanged.
    run(16'hC06A, 4, "busy_pulse", 1);
    @(negedge clk);
    check("busy_pulse_still_idle", 64'(act), 64'(exp_out(T_WAIT, 16'hC06A)));

    // Back-to-back: start held high; instr changes mid-flight.
    start = 1'b1;
    instr = 16'hD005;
    push_seq(16'hD005);
    exp_q.push_back(exp_out(T_WAIT, 16'hD005));
    push_seq(16'hD1FE);
    exp_q.push_back(exp_out(T_WAIT, 16'hD1FE));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pop_check($sformatf("b2b_cyc%0d", c));
      if (c == 0) instr = 16'hD1FE;
      if (c == 4) start = 1'b0;
    end

    // Asynchronous reset during EXEC of ADD: abandoned, no write-back.
    start = 1'b1;
    instr = 16'hA041;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_exec", 64'(act), 64'(exp_out(T_EX, 16'hA041)));
    #2 rst = 1'b1;
    #1 check("rst_async_immediate", 64'(act), 64'(exp_out(T_WAIT, 16'h0000)));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rst_no_write_cyc%0d", c), 64'(act),
            64'(exp_out(T_WAIT, 16'h0000)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
